// File: rtl/epfx_simd_pipe.sv
// SPU even-pipe SIMD fixed-point unit: byte/halfword/word lane arithmetic,
// full-width logicals, optional immediate operand, LAT-deep stallable/flushable pipe.

package epfx_simd_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SF   = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_AVG  = 4'd7;
  localparam logic [3:0] OP_ABSD = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_ROT  = 4'd10;
  localparam logic [3:0] OP_CEQ  = 4'd11;
  localparam logic [3:0] OP_CGT  = 4'd12;

  localparam logic [1:0] ES_BYTE = 2'b00;
  localparam logic [1:0] ES_HALF = 2'b01;
  localparam logic [1:0] ES_WORD = 2'b10;
endpackage

// One W-bit lane of the per-lane (non-logical) operations; W is a power of two.
module epfx_simd_lane #(
  parameter int W = 8
) (
  input  logic [3:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] r_o
);
  import epfx_simd_pkg::*;

  localparam int SW = $clog2(W);

  logic [SW:0]    cnt;
  logic [SW-1:0]  rot_cnt;
  logic [W-1:0]   avg;

  // Shift count spans 0..2W-1, so its top bit alone flags count >= W.
  assign cnt     = b_i[SW:0];
  assign rot_cnt = cnt[SW-1:0];

  // Equals (a+b+1)>>1 on a W+1-bit sum without needing the extra bit.
  assign avg = (a_i >> 1) + (b_i >> 1) + {{(W-1){1'b0}}, a_i[0] | b_i[0]};

  always_comb begin
    r_o = '0;
    case (op_i)
      OP_ADD:  r_o = a_i + b_i;
      OP_SF:   r_o = b_i - a_i;
      OP_AVG:  r_o = avg;
      OP_ABSD: r_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
      OP_SHL:  r_o = cnt[SW] ? '0 : (a_i << rot_cnt);
      OP_ROT:  r_o = (a_i << rot_cnt) | (a_i >> (W - int'(rot_cnt)));
      OP_CEQ:  r_o = (a_i == b_i) ? '1 : '0;
      OP_CGT:  r_o = ($signed(a_i) > $signed(b_i)) ? '1 : '0;
      default: r_o = '0;
    endcase
  end
endmodule

module epfx_simd_pipe #(
  parameter int WIDTH = 128,
  parameter int LAT   = 2,
  parameter int TAGW  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic [1:0]       esize,
  input  logic             imm_en,
  input  logic [9:0]       imm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAGW-1:0]  tag_in,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [TAGW-1:0]  out_tag
);
  import epfx_simd_pkg::*;

  // Handshake: an op is taken on an edge where in_valid=1, stall=0, flush=0
  // and reset=0. There is no ready; while stall=1 the caller holds its inputs
  // and every stage, including the outputs, freezes. flush beats stall,
  // reset beats both.

  logic [WIDTH-1:0] b_byte, b_half, b_word, b_log;
  logic [WIDTH-1:0] r_byte, r_half, r_word;
  logic [WIDTH-1:0] res_d;
  logic [LAT-1:0]   vld_d;

  logic [LAT-1:0]   vld_q;
  logic [WIDTH-1:0] res_q [LAT];
  logic [TAGW-1:0]  tag_q [LAT];

  assign b_byte = imm_en ? {(WIDTH/8){imm[7:0]}}              : b;
  assign b_half = imm_en ? {(WIDTH/16){{6{imm[9]}}, imm}}     : b;
  assign b_word = imm_en ? {(WIDTH/32){{22{imm[9]}}, imm}}    : b;

  always_comb begin
    b_log = b_word;
    case (esize)
      ES_BYTE: b_log = b_byte;
      ES_HALF: b_log = b_half;
      default: b_log = b_word;
    endcase
  end

  for (genvar i = 0; i < WIDTH/8; i++) begin : g_byte
    epfx_simd_lane #(.W(8)) u_lane (
      .op_i (op),
      .a_i  (a[i*8 +: 8]),
      .b_i  (b_byte[i*8 +: 8]),
      .r_o  (r_byte[i*8 +: 8])
    );
  end

  for (genvar i = 0; i < WIDTH/16; i++) begin : g_half
    epfx_simd_lane #(.W(16)) u_lane (
      .op_i (op),
      .a_i  (a[i*16 +: 16]),
      .b_i  (b_half[i*16 +: 16]),
      .r_o  (r_half[i*16 +: 16])
    );
  end

  for (genvar i = 0; i < WIDTH/32; i++) begin : g_word
    epfx_simd_lane #(.W(32)) u_lane (
      .op_i (op),
      .a_i  (a[i*32 +: 32]),
      .b_i  (b_word[i*32 +: 32]),
      .r_o  (r_word[i*32 +: 32])
    );
  end

  // Stage-1 compute: logicals ignore esize, lane ops return 0 for esize=11.
  always_comb begin
    res_d = '0;
    case (op)
      OP_AND:  res_d = a & b_log;
      OP_OR:   res_d = a | b_log;
      OP_XOR:  res_d = a ^ b_log;
      OP_NAND: res_d = ~(a & b_log);
      OP_NOR:  res_d = ~(a | b_log);
      OP_ADD, OP_SF, OP_AVG, OP_ABSD, OP_SHL, OP_ROT, OP_CEQ, OP_CGT: begin
        case (esize)
          ES_BYTE: res_d = r_byte;
          ES_HALF: res_d = r_half;
          ES_WORD: res_d = r_word;
          default: res_d = '0;
        endcase
      end
      default: res_d = '0;
    endcase
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int s = 1; s < LAT; s++) vld_d[s] = vld_q[s-1];
  end

  // Data/tag only load behind a valid op, so the outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        res_q[s] <= '0;
        tag_q[s] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q <= vld_d;
      if (in_valid) begin
        res_q[0] <= res_d;
        tag_q[0] <= tag_in;
      end
      for (int s = 1; s < LAT; s++) begin
        if (vld_q[s-1]) begin
          res_q[s] <= res_q[s-1];
          tag_q[s] <= tag_q[s-1];
        end
      end
    end
  end

  assign out_valid  = vld_q[LAT-1];
  assign out_result = res_q[LAT-1];
  assign out_tag    = tag_q[LAT-1];
endmodule

// File: tb/tb_epfx_simd_pipe.sv
// Testbench for epfx_simd_pipe: directed test-plan cases plus random traffic,
// checked every cycle against a lane-arithmetic reference and a latency queue.

module tb_epfx_simd_pipe;
  localparam int WIDTH = 128;
  localparam int LAT   = 2;
  localparam int TAGW  = 7;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [3:0]       op;
  logic [1:0]       esize;
  logic             imm_en;
  logic [9:0]       imm;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAGW-1:0]  tag_in;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [TAGW-1:0]  out_tag;

  int n_total = 0;
  int n_bad   = 0;
  int n_emit  = 0;
  int dtag    = 0;

  epfx_simd_pipe #(.WIDTH(WIDTH), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .op         (op),
    .esize      (esize),
    .imm_en     (imm_en),
    .imm        (imm),
    .a          (a),
    .b          (b),
    .tag_in     (tag_in),
    .stall      (stall),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tg, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] expv);
    n_total++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tg, got, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] rep(input int w, input longint unsigned v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH/w; i++) r = r | (WIDTH'(v) << (i*w));
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] ref_op(input logic [3:0] opc, input logic [1:0] es,
                                              input logic ie, input logic [9:0] im,
                                              input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int w;
    longint unsigned mask, x, y, r, cnt;
    longint sx, sy, simm;
    logic [WIDTH-1:0] bb, res;
    w    = (es == 2'd0) ? 8 : (es == 2'd1) ? 16 : 32;
    mask = (64'd1 << w) - 64'd1;
    simm = longint'($signed(im));
    bb   = ie ? rep(w, longint'(simm) & mask) : bv;
    res  = '0;
    case (opc)
      4'd2: return av & bb;
      4'd3: return av | bb;
      4'd4: return av ^ bb;
      4'd5: return ~(av & bb);
      4'd6: return ~(av | bb);
      4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
        if (es == 2'd3) return '0;
        for (int i = 0; i < WIDTH/w; i++) begin
          x = 64'(av >> (i*w)) & mask;
          y = 64'(bb >> (i*w)) & mask;
          r = 0;
          case (opc)
            4'd0:  r = x + y;
            4'd1:  r = y - x;
            4'd7:  r = (x + y + 1) >> 1;
            4'd8:  r = (x > y) ? x - y : y - x;
            4'd9: begin
              cnt = y % longint'(2*w);
              r = (cnt >= longint'(w)) ? 0 : (x << cnt);
            end
            4'd10: begin
              cnt = y % longint'(w);
              r = (x << cnt) | (x >> (longint'(w) - cnt));
            end
            4'd11: r = (x == y) ? mask : 0;
            default: begin
              sx = longint'(x);
              sy = longint'(y);
              if (((x >> (w-1)) & 1) != 0) sx = sx - (longint'(1) << w);
              if (((y >> (w-1)) & 1) != 0) sy = sy - (longint'(1) << w);
              r = (sx > sy) ? mask : 0;
            end
          endcase
          res = res | (WIDTH'(r & mask) << (i*w));
        end
        return res;
      end
      default: return '0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [TAGW+WIDTH-1:0] exp_q[$];
  int                    age_q[$];
  logic                  m_valid = 1'b0;
  logic [WIDTH-1:0]      m_res   = '0;
  logic [TAGW-1:0]       m_tag   = '0;
  bit                    seen_reset = 1'b0;

  // Each accepted op waits LAT-1 further advancing edges, then becomes the output.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      age_q.delete();
      m_valid = 1'b0;
      m_res = '0;
      m_tag = '0;
      seen_reset = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      age_q.delete();
      m_valid = 1'b0;
    end else if (!stall) begin
      m_valid = 1'b0;
      foreach (age_q[k]) age_q[k]--;
      if (in_valid) begin
        exp_q.push_back({tag_in, ref_op(op, esize, imm_en, imm, a, b)});
        age_q.push_back(LAT-1);
      end
      if (age_q.size() > 0 && age_q[0] == 0) begin
        {m_tag, m_res} = exp_q.pop_front();
        void'(age_q.pop_front());
        m_valid = 1'b1;
        n_emit++;
      end
    end
  end

  always @(negedge clk) begin
    if (seen_reset) begin
      check_eq("out_valid",  WIDTH'(out_valid), WIDTH'(m_valid));
      check_eq("out_tag",    WIDTH'(out_tag),   WIDTH'(m_tag));
      check_eq("out_result", out_result,        m_res);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int opc, input int es, input bit ie, input int im,
                      input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int tg);
    @(negedge clk);
    in_valid = 1'b1;
    op = 4'(opc);
    esize = 2'(es);
    imm_en = ie;
    imm = 10'(im);
    a = av;
    b = bv;
    tag_in = TAGW'(tg);
    stall = 1'b0;
    flush = 1'b0;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      reset = 1'b0;
    end
  endtask

  task automatic dir(input string nm, input int opc, input int es, input bit ie, input int im,
                     input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] expv);
    dtag = (dtag + 1) % 128;
    send(opc, es, ie, im, av, bv, dtag);
    idle(LAT);
    check_eq({nm, "_v"},   WIDTH'(out_valid), WIDTH'(1));
    check_eq({nm, "_tag"}, WIDTH'(out_tag),   WIDTH'(dtag));
    check_eq(nm,           out_result,        expv);
  endtask

  task automatic quiet(input string nm, input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      reset = 1'b0;
      check_eq(nm, WIDTH'(out_valid), WIDTH'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    op = '0;
    esize = '0;
    imm_en = 1'b0;
    imm = '0;
    a = '0;
    b = '0;
    tag_in = '0;
    stall = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid",  WIDTH'(out_valid), WIDTH'(0));
    check_eq("rst_result", out_result,        '0);
    check_eq("rst_tag",    WIDTH'(out_tag),   WIDTH'(0));

    // ADD word with tag 5
    dtag = 4;
    dir("add_w",    0, 2, 0, 0,     rep(32, 1),           rep(32, 2),          rep(32, 3));
    dir("add_b",    0, 0, 0, 0,     rep(8, 'hFF),         rep(8, 1),           '0);
    dir("add_h",    0, 1, 0, 0,     rep(16, 'hFFFF),      rep(16, 1),          '0);
    dir("sf_w",     1, 2, 0, 0,     rep(32, 5),           rep(32, 3),          rep(32, 'hFFFFFFFE));
    dir("avg_imm",  7, 0, 1, 'h3FF, rep(8, 1),            '0,                  rep(8, 'h80));
    dir("cgt_imm", 12, 2, 1, 'h3FF, '0,                   '0,                  '1);
    dir("shl_1",    9, 2, 0, 0,     rep(32, 'h80000001),  rep(32, 1),          rep(32, 2));
    dir("shl_32",   9, 2, 0, 0,     rep(32, 'h80000001),  rep(32, 32),         '0);
    dir("rot_33",  10, 2, 0, 0,     rep(32, 'h80000001),  rep(32, 33),         rep(32, 3));
    dir("rot_b",   10, 0, 0, 0,     rep(8, 'h81),         rep(8, 1),           rep(8, 3));
    dir("absd_b",   8, 0, 0, 0,     rep(8, 3),            rep(8, 10),          rep(8, 7));
    dir("ceq_h",   11, 1, 0, 0,     rep(32, 'h00051234),  rep(32, 'h00061234), rep(32, 'h0000FFFF));
    dir("nand",     5, 3, 0, 0,     rep(32, 'hF0F0F0F0),  rep(32, 'hFF00FF00), rep(32, 'h0FFF0FFF));
    dir("rsv_op",  13, 2, 0, 0,     '1,                   '1,                  '0);
    dir("rsv_es",   0, 3, 0, 0,     rep(32, 1),           rep(32, 1),          '0);

    // back-to-back with a 3-cycle stall while op 3 is held at the input
    send(0, 2, 0, 0, rep(32, 10), rep(32, 1), 21);
    send(0, 2, 0, 0, rep(32, 20), rep(32, 2), 22);
    send(0, 2, 0, 0, rep(32, 30), rep(32, 3), 23);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    stall = 1'b0;
    send(0, 2, 0, 0, rep(32, 40), rep(32, 4), 24);
    idle(LAT + 2);

    // flush on the cycle the second op is presented, then a normal op
    send(0, 1, 0, 0, rep(16, 7), rep(16, 7), 31);
    send(0, 1, 0, 0, rep(16, 8), rep(16, 8), 32);
    flush = 1'b1;
    stall = 1'b1;
    quiet("flush_quiet", LAT + 2);
    dir("post_flush", 0, 1, 0, 0, rep(16, 9), rep(16, 9), rep(16, 18));

    // reset on the cycle the second op is presented
    send(4, 2, 0, 0, rep(32, 'h55), rep(32, 'hFF), 41);
    send(4, 2, 0, 0, rep(32, 'hAA), rep(32, 'hFF), 42);
    reset = 1'b1;
    quiet("reset_quiet", LAT + 2);
    check_eq("reset_result", out_result, '0);
    dir("post_reset", 3, 0, 0, 0, rep(8, 'h0F), rep(8, 'h30), rep(8, 'h3F));

    // random traffic
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!stall) begin
        op = 4'($urandom_range(0, 15));
        esize = (op >= 4'd2 && op <= 4'd6) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
        imm_en = ($urandom_range(0, 3) == 0);
        imm = 10'($urandom_range(0, 1023));
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) b = b & rep(8, 'h0F);
        tag_in = TAGW'($urandom_range(0, 127));
        in_valid = ($urandom_range(0, 9) < 7);
      end
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 149) == 0);
    end
    idle(LAT + 3);
    check_eq("drain_empty", WIDTH'(exp_q.size()), WIDTH'(0));
    check_eq("emitted_some", WIDTH'(n_emit > 20), WIDTH'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
